// File: rtl/clock_divider_if.sv
// Control/status bundle for clock_divider: run/load/ratio in, divided clock and status out.
// master drives the controls; slave is the divider itself.
interface clock_divider_if #(
  parameter int WIDTH  = 8,
  parameter int PCNT_W = 16
);
  logic              en;
  logic              load;
  logic [WIDTH-1:0]  div;
  logic              clk_out;
  logic              tick;
  logic              running;
  logic [PCNT_W-1:0] periods;

  modport master (
    output en, load, div,
    input  clk_out, tick, running, periods
  );

  modport slave (
    input  en, load, div,
    output clk_out, tick, running, periods
  );
endinterface

// File: rtl/clock_divider.sv
// Programmable divide-by-N clock with drain-on-stop and glitch-free ratio updates at period wraps.
// First tick is one cycle after en; no backpressure: outputs are free-running registered levels/pulses.
module clock_divider #(
  parameter int WIDTH  = 8,
  parameter int PCNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  clock_divider_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  r_act_q, r_act_d;
  logic [WIDTH-1:0]  r_pend_q, r_pend_d;
  logic              pend_q, pend_d;
  logic              clk_out_q, clk_out_d;
  logic              tick_q, tick_d;
  logic [PCNT_W-1:0] periods_q, periods_d;

  logic [WIDTH-1:0]  r_eff;
  logic [WIDTH-1:0]  r_last;
  logic [WIDTH-1:0]  r_half;
  logic [WIDTH-1:0]  cnt_inc;
  logic              wrap;

  // Ratios below 2 cannot produce a high and a low phase, so they run as 2.
  assign r_eff   = (r_act_q < WIDTH'(2)) ? WIDTH'(2) : r_act_q;
  assign r_last  = r_eff - WIDTH'(1);
  assign r_half  = r_eff >> 1;
  assign cnt_inc = cnt_q + WIDTH'(1);
  assign wrap    = (cnt_q == r_last);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    r_act_d   = r_act_q;
    r_pend_d  = r_pend_q;
    pend_d    = pend_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    periods_d = periods_q;

    if (bus.load) begin
      r_pend_d = bus.div;
      pend_d   = 1'b1;
    end

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        clk_out_d = 1'b0;
        if (pend_q) begin
          r_act_d = r_pend_q;
          pend_d  = bus.load;
        end
        if (bus.en) begin
          state_d   = RUN;
          tick_d    = 1'b1;
          clk_out_d = 1'b1;
        end
      end

      RUN, DRAIN: begin
        if (wrap) begin
          cnt_d     = '0;
          periods_d = periods_q + PCNT_W'(1);
          // A load landing on the wrap itself beats any older pending ratio.
          if (bus.load) begin
            r_act_d = bus.div;
            pend_d  = 1'b0;
          end else if (pend_q) begin
            r_act_d = r_pend_q;
            pend_d  = 1'b0;
          end
          if (state_q == RUN || bus.en) begin
            tick_d    = 1'b1;
            clk_out_d = 1'b1;
            state_d   = bus.en ? RUN : DRAIN;
          end else begin
            clk_out_d = 1'b0;
            state_d   = IDLE;
          end
        end else begin
          cnt_d     = cnt_inc;
          clk_out_d = (cnt_inc < r_half);
          state_d   = bus.en ? RUN : DRAIN;
        end
      end

      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        clk_out_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      r_act_q   <= WIDTH'(2);
      r_pend_q  <= WIDTH'(2);
      pend_q    <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      periods_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      r_act_q   <= r_act_d;
      r_pend_q  <= r_pend_d;
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      periods_q <= periods_d;
    end
  end

  assign bus.clk_out = clk_out_q;
  assign bus.tick    = tick_q;
  assign bus.running = (state_q != IDLE);
  assign bus.periods = periods_q;

endmodule

// File: tb/tb_clock_divider.sv
// Directed bench for clock_divider: ratio loading, duty, drain/resume, reset abort, period-count wrap.
module tb_clock_divider;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  clock_divider_if #(.WIDTH(8), .PCNT_W(16)) bus ();
  clock_divider_if #(.WIDTH(8), .PCNT_W(4))  bus4 ();

  clock_divider #(.WIDTH(8), .PCNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  clock_divider #(.WIDTH(8), .PCNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Checks clk_out/tick against per-cycle '1'/'0' strings; load is a one-cycle strobe.
  task automatic expect_seq(input string tag, input string cp, input string tp);
    for (int i = 0; i < cp.len(); i++) begin
      chk($sformatf("%s.clk[%0d]", tag, i), {31'd0, bus.clk_out}, {31'd0, cp[i] == 8'h31});
      chk($sformatf("%s.tick[%0d]", tag, i), {31'd0, bus.tick}, {31'd0, tp[i] == 8'h31});
      step();
      bus.load = 1'b0;
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.en    = 1'b0;
    bus.load  = 1'b0;
    bus.div   = '0;
    bus4.en   = 1'b0;
    bus4.load = 1'b0;
    bus4.div  = '0;
    step();
    step();
    chk("rst.clk_out", {31'd0, bus.clk_out}, 32'd0);
    chk("rst.tick",    {31'd0, bus.tick},    32'd0);
    chk("rst.running", {31'd0, bus.running}, 32'd0);
    chk("rst.periods", {16'd0, bus.periods}, 32'd0);
    rst = 1'b0;

    // div=4, en held: 1100 pattern, tick every 4th cycle, 4 periods after 16 run cycles
    bus.load = 1'b1;
    bus.div  = 8'd4;
    expect_seq("idle", "00", "00");
    bus.en = 1'b1;
    expect_seq("a_lat", "0", "0");
    expect_seq("r4", "1100110011001100", "1000100010001000");
    chk("r4.periods", {16'd0, bus.periods}, 32'd4);
    chk("r4.running", {31'd0, bus.running}, 32'd1);

    // div=5 takes effect after the current R=4 period; then div=0 and div=1 run as R=2
    bus.load = 1'b1;
    bus.div  = 8'd5;
    expect_seq("r4tail", "1100", "1000");
    expect_seq("r5", "1100011000", "1000010000");
    bus.load = 1'b1;
    bus.div  = 8'd0;
    expect_seq("r5c", "11000", "10000");
    expect_seq("div0", "1010", "1010");
    bus.load = 1'b1;
    bus.div  = 8'd1;
    expect_seq("r2a", "10", "10");
    expect_seq("div1", "1010", "1010");

    // mid-period load of 6 waits for the wrap; load of 3 on the wrap governs the next period
    bus.load = 1'b1;
    bus.div  = 8'd4;
    expect_seq("r2c", "10", "10");
    expect_seq("r4c0", "1", "1");
    bus.load = 1'b1;
    bus.div  = 8'd6;
    expect_seq("r4c1", "100", "000");
    expect_seq("r6", "11100", "10000");
    bus.load = 1'b1;
    bus.div  = 8'd3;
    expect_seq("r6w", "0", "0");
    bus.load = 1'b1;
    bus.div  = 8'd8;
    expect_seq("r3", "100", "100");
    chk("r3.periods", {16'd0, bus.periods}, 32'd17);

    // R=8, en dropped at cnt=1: drain 6 more cycles, then idle with no extra tick
    expect_seq("r8a", "1", "1");
    bus.en = 1'b0;
    expect_seq("drain", "111000", "000000");
    chk("drain.running_pre", {31'd0, bus.running}, 32'd1);
    expect_seq("drain_last", "0", "0");
    chk("drain.running", {31'd0, bus.running}, 32'd0);
    expect_seq("idle_hold", "00", "00");
    chk("drain.periods", {16'd0, bus.periods}, 32'd18);

    // repeat, with en re-raised at cnt=5: periods continue without a gap
    bus.en = 1'b1;
    expect_seq("idle_en", "0", "0");
    expect_seq("r8b", "1", "1");
    bus.en = 1'b0;
    expect_seq("r8b2", "1110", "0000");
    chk("resume.running", {31'd0, bus.running}, 32'd1);
    bus.en = 1'b1;
    expect_seq("r8b3", "000", "000");
    expect_seq("r8b4", "11110000", "10000000");
    chk("resume.periods", {16'd0, bus.periods}, 32'd20);

    // reset at cnt=3 with load and en high: reset wins, load is discarded
    expect_seq("r8c", "111", "100");
    rst      = 1'b1;
    bus.load = 1'b1;
    bus.div  = 8'd6;
    step();
    rst      = 1'b0;
    bus.load = 1'b0;
    chk("abort.clk_out", {31'd0, bus.clk_out}, 32'd0);
    chk("abort.tick",    {31'd0, bus.tick},    32'd0);
    chk("abort.running", {31'd0, bus.running}, 32'd0);
    chk("abort.periods", {16'd0, bus.periods}, 32'd0);
    step();
    expect_seq("post_rst", "1010", "1010");
    chk("post_rst.periods", {16'd0, bus.periods}, 32'd2);

    // 4-bit period counter at R=2 wraps after 16 periods
    chk("p4.start", {28'd0, bus4.periods}, 32'd0);
    bus4.en = 1'b1;
    step();
    for (int i = 0; i < 32; i++) step();
    chk("p4.16", {28'd0, bus4.periods}, 32'd0);
    step();
    step();
    chk("p4.17", {28'd0, bus4.periods}, 32'd1);
    chk("p4.tick", {31'd0, bus4.tick}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
